// File: rtl/key_pkg.sv
// Shared key constants, key-code type and the lowest-set-bit encoder.
package key_pkg;

    localparam int unsigned NKEYS  = 16;
    localparam int unsigned CODE_W = $clog2(NKEYS);

    typedef logic [CODE_W-1:0] key_code_t;

    typedef struct packed {
        logic      found;
        key_code_t idx;
    } lsb_t;

    function automatic lsb_t lsb_index(input logic [NKEYS-1:0] v);
        lsb_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (v[i] && !r.found) begin
                r.found = 1'b1;
                r.idx   = key_code_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, combinational head read and same-cycle push/pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        do_push  = push && ((count_q != FULL) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/key_event_queue.sv
// Turns one-hot key press pulses into an ordered stream of key codes behind a valid/ready FIFO.
module key_event_queue
    import key_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NKEYS-1:0]       press,
    output key_code_t              code,
    output logic                   valid,
    input  logic                   ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [NKEYS-1:0] pending_q, pending_d;
    logic [NKEYS-1:0] grant;
    logic             overflow_q, overflow_d;
    logic             pop, push, push_ok;
    lsb_t             lsb;

    always_comb begin
        lsb     = lsb_index(pending_q);
        pop     = valid && ready;
        push_ok = (count != FULL) || pop;
        grant   = '0;
        if (lsb.found && push_ok) begin
            grant[lsb.idx] = 1'b1;
        end
        push       = |grant;
        // A press landing on its own grant cycle re-arms the bit instead of counting as a repeat.
        pending_d  = (pending_q & ~grant) | press;
        overflow_d = |(press & pending_q & ~grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (lsb.idx),
        .pop   (pop),
        .dout  (code),
        .count (count)
    );

    assign valid    = (count != '0);
    assign overflow = overflow_q;

endmodule
